// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : State encoding and default constants shared by the fetch blocks.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_PC_STEP  = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_out_stage
// Brief    : Decode-facing output slot plus a one-entry skid register pair.
// Revision : 1.0
// ============================================================================
module fetch_out_stage
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load_slot,
    input  logic              load_skid,
    input  logic              drain,
    input  logic              stall,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc
);

    logic [DATA_W-1:0] r_skid_data;
    logic [ADDR_W-1:0] r_skid_pc;

    // Occupancy of the skid is tracked by the sequencer's FULL state, so only
    // the data/address pair lives here.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= 1'b0;
            instr       <= '0;
            pc          <= '0;
            r_skid_data <= '0;
            r_skid_pc   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else begin
            if (load_slot) begin
                valid <= 1'b1;
                instr <= in_data;
                pc    <= in_pc;
            end else if (drain) begin
                valid <= 1'b1;
                instr <= r_skid_data;
                pc    <= r_skid_pc;
            end else if (valid && !stall) begin
                valid <= 1'b0;
            end
            if (load_skid) begin
                r_skid_data <= in_data;
                r_skid_pc   <= in_pc;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC owner and instruction-memory handshake with redirect handling.
// Revision : 1.0
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int                PC_STEP  = DEF_PC_STEP
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemReady,
    input  logic [DATA_W-1:0] ImemData,
    output logic              IfValid,
    output logic [DATA_W-1:0] IfInstruction,
    output logic [ADDR_W-1:0] IfPC
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] r_target;
    logic [ADDR_W-1:0] w_target_nxt;
    logic              r_discard;
    logic              w_discard_nxt;
    logic              w_load_slot;
    logic              w_load_skid;
    logic              w_drain;
    logic              w_slot_free;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_slot_free = !IfValid || !Stall;
    assign w_addr_inc  = r_addr + ADDR_W'(PC_STEP);
    assign ImemReq     = (r_state == BUSY);
    assign ImemAddr    = r_addr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_addr    <= RESET_PC;
            r_target  <= '0;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_target  <= w_target_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_target_nxt  = r_target;
        w_discard_nxt = r_discard;
        w_load_slot   = 1'b0;
        w_load_skid   = 1'b0;
        w_drain       = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = BUSY;
                if (Redirect) begin
                    w_addr_nxt = RedirectPC;
                end
            end
            BUSY: begin
                if (ImemReady) begin
                    // A redirect on the ready edge takes precedence over a stale target.
                    if (Redirect) begin
                        w_addr_nxt    = RedirectPC;
                        w_discard_nxt = 1'b0;
                    end else if (r_discard) begin
                        w_addr_nxt    = r_target;
                        w_discard_nxt = 1'b0;
                    end else if (w_slot_free) begin
                        w_load_slot = 1'b1;
                        w_addr_nxt  = w_addr_inc;
                    end else begin
                        w_load_skid = 1'b1;
                        w_addr_nxt  = w_addr_inc;
                        w_state_nxt = FULL;
                    end
                end else if (Redirect) begin
                    // The request in flight cannot be withdrawn; remember where to go.
                    w_target_nxt  = RedirectPC;
                    w_discard_nxt = 1'b1;
                end
            end
            FULL: begin
                if (Redirect) begin
                    w_addr_nxt  = RedirectPC;
                    w_state_nxt = BUSY;
                end else if (!Stall) begin
                    w_drain     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    fetch_out_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk       (Clk),
        .rst       (Reset),
        .flush     (Redirect),
        .load_slot (w_load_slot),
        .load_skid (w_load_skid),
        .drain     (w_drain),
        .stall     (Stall),
        .in_data   (ImemData),
        .in_pc     (r_addr),
        .valid     (IfValid),
        .instr     (IfInstruction),
        .pc        (IfPC)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Directed scenarios plus randomized stream checks for fetch_sequencer.
// Revision : 1.0
// ============================================================================
module tb_fetch_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemData;
    logic        IfValid;
    logic [31:0] IfInstruction;
    logic [31:0] IfPC;

    logic        hi_req;
    logic [31:0] hi_addr;
    logic [31:0] hi_data;
    logic        hi_valid;
    logic [31:0] hi_instr;
    logic [31:0] hi_pc;

    int          n_tests;
    int          n_fail;
    int          n_xfer;
    logic [31:0] exp_pc;
    bit          req_active;
    int          wait_left;
    int          mem_wait;
    bit          mem_rand;

    // Memory contents: a bijective scramble of the address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    assign ImemData = memword(ImemAddr);
    assign hi_data  = memword(hi_addr);

    fetch_sequencer u_dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Stall         (Stall),
        .Redirect      (Redirect),
        .RedirectPC    (RedirectPC),
        .ImemReq       (ImemReq),
        .ImemAddr      (ImemAddr),
        .ImemReady     (ImemReady),
        .ImemData      (ImemData),
        .IfValid       (IfValid),
        .IfInstruction (IfInstruction),
        .IfPC          (IfPC)
    );

    fetch_sequencer #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_dut_hi (
        .Clk           (Clk),
        .Reset         (Reset),
        .Stall         (Stall),
        .Redirect      (Redirect),
        .RedirectPC    (RedirectPC),
        .ImemReq       (hi_req),
        .ImemAddr      (hi_addr),
        .ImemReady     (ImemReady),
        .ImemData      (hi_data),
        .IfValid       (hi_valid),
        .IfInstruction (hi_instr),
        .IfPC          (hi_pc)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: scoreboard the edge that just happened, then model the memory.
    task automatic tick();
        logic        e_rst, e_stall, e_redir, e_ready, p_valid, p_req;
        logic [31:0] e_rpc, p_pc, p_instr, p_addr;
        e_rst   = Reset;
        e_stall = Stall;
        e_redir = Redirect;
        e_rpc   = RedirectPC;
        e_ready = ImemReady;
        p_valid = IfValid;
        p_pc    = IfPC;
        p_instr = IfInstruction;
        p_req   = ImemReq;
        p_addr  = ImemAddr;
        @(posedge Clk);
        #1;
        if (e_rst) begin
            exp_pc     = 32'h0;
            req_active = 1'b0;
        end else begin
            if (p_req && !e_ready)
                check("hs_hold", 96'({ImemReq, ImemAddr}), 96'({1'b1, p_addr}));
            if (e_redir) begin
                check("redir_flush", 96'(IfValid), 96'(0));
                exp_pc = e_rpc;
            end else begin
                if (p_valid && e_stall)
                    check("stall_hold", 96'({IfValid, IfPC, IfInstruction}),
                          96'({1'b1, p_pc, p_instr}));
                if (p_valid && !e_stall) begin
                    check("xfer_pc", 96'(p_pc), 96'(exp_pc));
                    check("xfer_data", 96'(p_instr), 96'(memword(p_pc)));
                    exp_pc = exp_pc + 32'd4;
                    n_xfer++;
                end
            end
            if (req_active) begin
                if (e_ready)
                    req_active = 1'b0;
                else if (wait_left != 0)
                    wait_left--;
            end
        end
        if (ImemReq && !req_active) begin
            req_active = 1'b1;
            wait_left  = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
        end
        ImemReady = req_active && (wait_left == 0);
    endtask

    task automatic do_reset(input int waits);
        Reset    = 1'b1;
        mem_wait = waits;
        tick();
        Reset    = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (IfValid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        bit          found;
        bit          saw_old;
        int          xfer0;
        logic [31:0] hpc;
        n_tests    = 0;
        n_fail     = 0;
        n_xfer     = 0;
        exp_pc     = 32'h0;
        req_active = 1'b0;
        wait_left  = 0;
        mem_wait   = 0;
        mem_rand   = 1'b0;
        Reset      = 1'b1;
        Stall      = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 32'h0;
        ImemReady  = 1'b0;
        tick();
        tick();

        check("rst_state", 96'({ImemReq, ImemAddr, IfValid, IfPC, IfInstruction}), 96'(0));
        check("rst_hi_addr", 96'({hi_req, hi_addr}), 96'({1'b0, 32'hFFFF_FFF8}));

        // 0-wait streaming, both reset vectors
        Reset    = 1'b0;
        mem_wait = 0;
        tick();
        check("t1_idle", 96'({IfValid, ImemReq, ImemAddr}), 96'({1'b0, 1'b1, 32'h0}));
        for (int k = 0; k < 4; k++) begin
            tick();
            hpc = 32'hFFFF_FFF8 + 32'(4 * k);
            check("t1_pc", 96'({IfValid, IfPC, IfInstruction}),
                  96'({1'b1, 32'(4 * k), memword(32'(4 * k))}));
            if (k < 3)
                check("t1_hi_pc", 96'({hi_valid, hi_pc, hi_instr}), 96'({1'b1, hpc, memword(hpc)}));
        end

        // 2-wait memory
        do_reset(2);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_hold", 96'({ImemReq, ImemAddr, IfValid}), 96'({1'b1, 32'h0, 1'b0}));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_valid", 96'({IfValid, IfPC}), 96'({1'b1, 32'(4 * k)}));
            tick();
            check("t2_gap", 96'(IfValid), 96'(0));
            tick();
            check("t2_gap", 96'(IfValid), 96'(0));
        end

        // Stall with 0-wait memory: skid fills, FULL drops the request
        do_reset(0);
        for (int k = 0; k < 4; k++) tick();
        check("t3_pre", 96'({IfValid, IfPC}), 96'({1'b1, 32'h8}));
        Stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_frozen", 96'({IfValid, IfPC, IfInstruction}), 96'({1'b1, 32'h8, memword(32'h8)}));
            check("t3_full", 96'({ImemReq, ImemAddr}), 96'({1'b0, 32'h10}));
        end
        Stall = 1'b0;
        tick();
        check("t3_skid", 96'({IfValid, IfPC}), 96'({1'b1, 32'hC}));
        tick();
        check("t3_next", 96'({IfValid, IfPC}), 96'({1'b1, 32'h10}));

        // Redirect while a 3-wait request at 0x10 is outstanding
        do_reset(3);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ImemReq && ImemAddr == 32'h10) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t4_reach", 96'(found), 96'(1));
        Redirect   = 1'b1;
        RedirectPC = 32'h100;
        tick();
        Redirect = 1'b0;
        check("t4_flush", 96'({IfValid, ImemReq, ImemAddr}), 96'({1'b0, 1'b1, 32'h10}));
        saw_old = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ImemAddr != 32'h10) begin
                found = 1'b1;
                break;
            end
            tick();
            if (IfValid && IfPC == 32'h10) saw_old = 1'b1;
        end
        check("t4_new_addr", 96'({found, ImemAddr}), 96'({1'b1, 32'h100}));
        check("t4_dropped", 96'(saw_old), 96'(0));
        wait_valid(found);
        check("t4_first_pc", 96'({found, IfPC}), 96'({1'b1, 32'h100}));

        // Redirect on the ready edge, then redirect under stall
        mem_wait = 0;
        found    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ImemReq && ImemReady) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t5_reach", 96'(found), 96'(1));
        Redirect   = 1'b1;
        RedirectPC = 32'h200;
        tick();
        Redirect = 1'b0;
        check("t5_flush", 96'({IfValid, ImemReq, ImemAddr}), 96'({1'b0, 1'b1, 32'h200}));
        tick();
        check("t5_first_pc", 96'({IfValid, IfPC}), 96'({1'b1, 32'h200}));
        Stall = 1'b1;
        tick();
        tick();
        Redirect   = 1'b1;
        RedirectPC = 32'h300;
        tick();
        Redirect = 1'b0;
        check("t5_stall_flush", 96'({IfValid, ImemReq, ImemAddr}), 96'({1'b0, 1'b1, 32'h300}));
        Stall = 1'b0;
        wait_valid(found);
        check("t5_stall_pc", 96'({found, IfPC}), 96'({1'b1, 32'h300}));

        // Reset in the middle of a request; a late ready in IDLE is ignored
        mem_wait = 2;
        found    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ImemReq && !ImemReady) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t6_reach", 96'(found), 96'(1));
        Reset = 1'b1;
        tick();
        check("t6_abandon", 96'({ImemReq, IfValid, ImemAddr}), 96'({1'b0, 1'b0, 32'h0}));
        Reset     = 1'b0;
        ImemReady = 1'b1;
        tick();
        check("t6_idle_ready", 96'({IfValid, ImemReq, ImemAddr}), 96'({1'b0, 1'b1, 32'h0}));
        wait_valid(found);
        check("t6_resume", 96'({found, IfPC, IfInstruction}), 96'({1'b1, 32'h0, memword(32'h0)}));

        // Randomized traffic against the stream scoreboard
        mem_rand = 1'b1;
        xfer0    = n_xfer;
        for (int i = 0; i < 2000; i++) begin
            Stall      = ($urandom_range(0, 9) < 3);
            Redirect   = ($urandom_range(0, 19) == 0);
            RedirectPC = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'($urandom);
            tick();
        end
        Stall    = 1'b0;
        Redirect = 1'b0;
        check("rand_progress", 96'(n_xfer - xfer0 >= 100), 96'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
